// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI slave core.
// Holds FSM encoding, SPI mode bundle, edge selection and underrun fill.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam logic [7:0] TX_IDLE_DEF = 8'hFF;

    // Returns {sample, shift} strobes for the given mode.
    // Leading edge = SCK leaving its cpol idle level.
    function automatic logic [1:0] edge_sel(
        input spi_mode_t m,
        input logic      rise,
        input logic      fall
    );
        logic lead;
        logic trail;
        lead  = m.cpol ? fall : rise;
        trail = m.cpol ? rise : fall;
        return m.cpha ? {trail, lead} : {lead, trail};
    endfunction

endpackage

// File: rtl/spi_slave_core_in_sync.sv
// spi_in_sync: synchronises cs/sck/mosi into clk and flags cs/sck edges.
// Ports: clk, rst_n, spi_cs/spi_sck/spi_mosi in; cs_s, edge pulses, mosi_s out.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_cs,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic cs_s,
    output logic cs_rise,
    output logic cs_fall,
    output logic sck_rise,
    output logic sck_fall,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   cs_d;
    logic                   sck_d;
    logic                   sck_s;

    // cs resets to the deselected level so no false fall follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q   <= '1;
            sck_q  <= '0;
            mosi_q <= '0;
            cs_d   <= 1'b1;
            sck_d  <= 1'b0;
        end else begin
            cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs};
            sck_q  <= {sck_q[SYNC_STAGES-2:0], spi_sck};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
            cs_d   <= cs_s;
            sck_d  <= sck_s;
        end
    end

    assign cs_s     = cs_q[SYNC_STAGES-1];
    assign sck_s    = sck_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;

endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampling SPI slave, all cpol/cpha modes, 1-deep TX buffer.
// Ports: pads (spi_cs/sck/mosi/miso/miso_oe), mode (cpol/cpha), tx and rx
// valid/ready streams, busy. Optional rx_ovr/tx_urun with SPI_SLAVE_OVR_DET_EN.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE     = DATA_WIDTH'(TX_IDLE_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  spi_cs,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy
`ifdef SPI_SLAVE_OVR_DET_EN
   ,output logic                  rx_ovr,
    output logic                  tx_urun
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    spi_state_e            state_q;
    spi_state_e            state_d;
    spi_mode_t             mode;
    logic                  cs_s;
    logic                  cs_rise;
    logic                  cs_fall;
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  mosi_s;
    logic                  sample_e;
    logic                  shift_e;
    logic                  do_load;
    logic                  in_xfer;
    logic                  abort;
    logic                  word_done;
    logic                  reload;
    logic                  tx_accept;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [DATA_WIDTH-1:0] shifter;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [CNT_W-1:0]      bit_cnt;

    spi_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .spi_cs  (spi_cs),
        .spi_sck (spi_sck),
        .spi_mosi(spi_mosi),
        .cs_s    (cs_s),
        .cs_rise (cs_rise),
        .cs_fall (cs_fall),
        .sck_rise(sck_rise),
        .sck_fall(sck_fall),
        .mosi_s  (mosi_s)
    );

    assign mode                = '{cpol: cpol, cpha: cpha};
    assign {sample_e, shift_e} = edge_sel(mode, sck_rise, sck_fall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = LOAD;
            LOAD:    state_d = cs_rise ? IDLE : XFER;
            XFER:    if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_load = 1'b0;
        in_xfer = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            LOAD: begin
                do_load = !cs_rise;
                abort   = cs_rise;
            end
            XFER: begin
                in_xfer = !cs_rise;
                abort   = cs_rise;
            end
            default: ;
        endcase
    end

    assign rx_word   = {rx_shift, mosi_s};
    assign word_done = in_xfer && sample_e && (bit_cnt == LAST);
    assign reload    = do_load || word_done;
    assign tx_word   = buf_valid ? tx_buf : TX_IDLE;
    assign tx_accept = tx_valid && !buf_valid;
    assign tx_ready  = !buf_valid;
    assign busy      = !cs_s;

    // Accept only into an empty buffer, so it never collides with a reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            tx_buf    <= '0;
        end else begin
            if (reload && buf_valid) buf_valid <= 1'b0;
            if (tx_accept) begin
                tx_buf    <= tx_data;
                buf_valid <= 1'b1;
            end
        end
    end

    // cpha=0 puts the MSB out at load and pre-shifts; cpha=1 presents it
    // on the first leading edge. Reloads always present on the next shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            shifter     <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
        end else if (abort || state_q == IDLE) begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            bit_cnt     <= '0;
        end else if (do_load) begin
            spi_miso_oe <= 1'b1;
            spi_miso    <= tx_word[DATA_WIDTH-1];
            shifter     <= cpha ? tx_word : {tx_word[DATA_WIDTH-2:0], 1'b0};
            bit_cnt     <= '0;
        end else if (in_xfer) begin
            if (sample_e) begin
                rx_shift <= rx_word[DATA_WIDTH-2:0];
                bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
                if (word_done) shifter <= tx_word;
            end else if (shift_e) begin
                spi_miso <= shifter[DATA_WIDTH-1];
                shifter  <= {shifter[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (word_done) begin
            rx_data  <= rx_word;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_OVR_DET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovr  <= 1'b0;
            tx_urun <= 1'b0;
        end else begin
            rx_ovr  <= word_done && rx_valid;
            tx_urun <= reload && !buf_valid;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: directed table-driven bench for spi_slave_core.
// Drives a timed SPI master at f_clk = 10*f_sck and checks every mode.
module tb_spi_slave_core;

    localparam int H = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpol;
    logic       cpha;
    logic       spi_cs;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
`ifdef SPI_SLAVE_OVR_DET_EN
    logic       rx_ovr;
    logic       tx_urun;
    int         ovr_cnt = 0;
    int         urun_cnt = 0;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   rxv_cnt = 0;
    logic rxv_d = 1'b0;

    spi_slave_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpol       (cpol),
        .cpha       (cpha),
        .spi_cs     (spi_cs),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy)
`ifdef SPI_SLAVE_OVR_DET_EN
       ,.rx_ovr     (rx_ovr),
        .tx_urun    (tx_urun)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rxv_d <= rx_valid;
        if (rx_valid && !rxv_d) rxv_cnt <= rxv_cnt + 1;
`ifdef SPI_SLAVE_OVR_DET_EN
        if (rx_ovr)  ovr_cnt  <= ovr_cnt + 1;
        if (tx_urun) urun_cnt <= urun_cnt + 1;
`endif
    end

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol    = p;
        cpha    = h;
        spi_sck = p;
        #200;
    endtask

    task automatic cs_start();
        spi_cs = 1'b0;
        #100;
    endtask

    task automatic cs_stop();
        #H;
        spi_cs = 1'b1;
        #200;
    endtask

    // Master: MSB first, samples MISO at its sample edge and rechecks it
    // just before the next shift edge to catch off-edge MISO changes.
    task automatic spi_bits(input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi, output logic stable);
        mi     = 8'h00;
        stable = 1'b1;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                spi_mosi = mo[i];
                #H;
                spi_sck = ~cpol;
                mi[i]   = spi_miso;
                #(H - 10);
                if (spi_miso !== mi[i]) stable = 1'b0;
                #10;
                spi_sck = cpol;
            end else begin
                spi_sck  = ~cpol;
                spi_mosi = mo[i];
                #H;
                spi_sck = cpol;
                mi[i]   = spi_miso;
                #(H - 10);
                if (spi_miso !== mi[i]) stable = 1'b0;
                #10;
            end
        end
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mi2;
        logic       st;
        int         c0;
`ifdef SPI_SLAVE_OVR_DET_EN
        int         o0;
        int         u0;
`endif

        vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[2] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[3] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[5] = '{1'b1, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[6] = '{1'b0, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};

        rst_n    = 1'b1;
        cpol     = 1'b0;
        cpha     = 1'b0;
        spi_cs   = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_miso", {7'd0, spi_miso}, 8'h00);
        chk("rst_oe", {7'd0, spi_miso_oe}, 8'h00);
        chk("rst_tx_ready", {7'd0, tx_ready}, 8'h01);
        chk("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
`ifdef SPI_SLAVE_OVR_DET_EN
        chk("rst_rx_ovr", {7'd0, rx_ovr}, 8'h00);
`endif
        #50 rst_n = 1'b1;
        #100;

        for (int v = 0; v < 7; v++) begin
            set_mode(vecs[v].cpol, vecs[v].cpha);
            c0 = rxv_cnt;
            push_tx(vecs[v].tx);
            chk($sformatf("v%0d_tx_full", v), {7'd0, tx_ready}, 8'h00);
            cs_start();
            chk($sformatf("v%0d_busy", v), {7'd0, busy}, 8'h01);
            chk($sformatf("v%0d_oe", v), {7'd0, spi_miso_oe}, 8'h01);
            spi_bits(vecs[v].mosi, 8, mi, st);
            cs_stop();
            chk($sformatf("v%0d_miso", v), mi, vecs[v].exp_miso);
            chk($sformatf("v%0d_rx", v), rx_data, vecs[v].exp_rx);
            chk($sformatf("v%0d_rxv", v), {7'd0, rx_valid}, 8'h01);
            chk($sformatf("v%0d_rxv_cnt", v), 8'(rxv_cnt - c0), 8'h01);
            chk($sformatf("v%0d_stable", v), {7'd0, st}, 8'h01);
            chk($sformatf("v%0d_tx_empty", v), {7'd0, tx_ready}, 8'h01);
            chk($sformatf("v%0d_oe_off", v), {7'd0, spi_miso_oe}, 8'h00);
            chk($sformatf("v%0d_idle", v), {7'd0, busy}, 8'h00);
            pop_rx();
            chk($sformatf("v%0d_rxv_clr", v), {7'd0, rx_valid}, 8'h00);
        end

        // Back-to-back words, second one underruns, rx never accepted.
        set_mode(1'b0, 1'b0);
        c0 = rxv_cnt;
`ifdef SPI_SLAVE_OVR_DET_EN
        o0 = ovr_cnt;
        u0 = urun_cnt;
`endif
        push_tx(8'hA5);
        cs_start();
        spi_bits(8'h01, 8, mi, st);
        chk("b2b_rx1", rx_data, 8'h01);
`ifdef SPI_SLAVE_OVR_DET_EN
        chk("b2b_urun", 8'(urun_cnt - u0), 8'h01);
`endif
        spi_bits(8'h02, 8, mi2, st);
        cs_stop();
        chk("b2b_miso1", mi, 8'hA5);
        chk("b2b_miso2", mi2, 8'hFF);
        chk("b2b_rx2", rx_data, 8'h02);
        chk("b2b_rxv", {7'd0, rx_valid}, 8'h01);
        chk("b2b_rxv_cnt", 8'(rxv_cnt - c0), 8'h01);
`ifdef SPI_SLAVE_OVR_DET_EN
        chk("b2b_ovr", 8'(ovr_cnt - o0), 8'h01);
`endif
        pop_rx();

        // Second push while the buffer is full is dropped.
        push_tx(8'h11);
        push_tx(8'h22);
        cs_start();
        spi_bits(8'h55, 8, mi, st);
        cs_stop();
        chk("ign_miso", mi, 8'h11);
        chk("ign_rx", rx_data, 8'h55);
        chk("ign_tx_empty", {7'd0, tx_ready}, 8'h01);
        pop_rx();

        // cs released after 5 bits.
        c0 = rxv_cnt;
        cs_start();
        spi_bits(8'h96, 5, mi, st);
        cs_stop();
        chk("abort_rxv", {7'd0, rx_valid}, 8'h00);
        chk("abort_rxv_cnt", 8'(rxv_cnt - c0), 8'h00);
        chk("abort_oe", {7'd0, spi_miso_oe}, 8'h00);
        chk("abort_miso", {7'd0, spi_miso}, 8'h00);
        cs_start();
        spi_bits(8'h11, 8, mi, st);
        cs_stop();
        chk("after_abort_rx", rx_data, 8'h11);
        chk("after_abort_miso", mi, 8'hFF);
        chk("after_abort_rxv", {7'd0, rx_valid}, 8'h01);

        // Reset in the middle of a word, rx word still pending.
        push_tx(8'h5A);
        cs_start();
        spi_bits(8'hC3, 3, mi, st);
        rst_n = 1'b0;
        #1;
        chk("mrst_miso", {7'd0, spi_miso}, 8'h00);
        chk("mrst_oe", {7'd0, spi_miso_oe}, 8'h00);
        chk("mrst_tx_ready", {7'd0, tx_ready}, 8'h01);
        chk("mrst_rxv", {7'd0, rx_valid}, 8'h00);
        chk("mrst_rx_data", rx_data, 8'h00);
        chk("mrst_busy", {7'd0, busy}, 8'h00);
        spi_cs  = 1'b1;
        spi_sck = cpol;
        #100 rst_n = 1'b1;
        #200;
        push_tx(8'h5A);
        cs_start();
        spi_bits(8'h77, 8, mi, st);
        cs_stop();
        chk("post_rst_miso", mi, 8'h5A);
        chk("post_rst_rx", rx_data, 8'h77);
        chk("post_rst_rxv", {7'd0, rx_valid}, 8'h01);
        pop_rx();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
